// File: rtl/prog_mem.sv
// Writable instruction memory for the toy CPU: one-cycle registered fetch,
// program-load write port with a sticky lock, default program restored on reset.
module prog_mem #(
    parameter int              DEPTH  = 4,
    parameter int              ADDR_W = 2,
    parameter int              OP_W   = 2,
    parameter logic [OP_W-1:0] HLT_OP = OP_W'(2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [OP_W-1:0]   fetch_data,
    output logic              fetch_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [OP_W-1:0]   wr_data,
    output logic              wr_err,
    input  logic              lock_set,
    output logic              locked
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Default program: INC, JNO, INC, HLT, remaining entries filled with HLT_OP.
    function automatic logic [OP_W-1:0] default_op(input int idx);
        case (idx)
            0:       default_op = OP_W'(0);
            1:       default_op = OP_W'(1);
            2:       default_op = OP_W'(0);
            3:       default_op = OP_W'(2);
            default: default_op = HLT_OP;
        endcase
    endfunction

    logic [OP_W-1:0] mem_q [DEPTH];
    lock_state_e     lock_q;
    logic            fetch_valid_q;
    logic            fetch_err_q;
    logic [OP_W-1:0] fetch_data_q;
    logic            wr_err_q;

    logic            fetch_in_range;
    logic            wr_in_range;
    logic            wr_ok;
    logic [OP_W-1:0] rd_word;
    logic [OP_W-1:0] fetch_data_d;

    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_X;
    assign wr_in_range    = {1'b0, wr_addr} < DEPTH_X;
    // Write is judged against the lock state before this edge.
    assign wr_ok          = wr_en && (lock_q == UNLOCKED) && wr_in_range;

    always_comb begin
        rd_word = HLT_OP;
        for (int i = 0; i < DEPTH; i++) begin
            if (fetch_addr == ADDR_W'(i)) begin
                rd_word = mem_q[i];
            end
        end
        fetch_data_d = rd_word;
        if (wr_ok && (wr_addr == fetch_addr)) begin
            fetch_data_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= default_op(i);
            end
            lock_q        <= UNLOCKED;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_data_q  <= '0;
            wr_err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    mem_q[i] <= wr_data;
                end
            end
            if (lock_set) begin
                lock_q <= LOCKED;
            end
            fetch_valid_q <= fetch_req;
            fetch_err_q   <= fetch_req && !fetch_in_range;
            if (fetch_req) begin
                fetch_data_q <= fetch_data_d;
            end
            wr_err_q <= wr_en && !wr_ok;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_data  = fetch_data_q;
    assign wr_err      = wr_err_q;
    assign locked      = (lock_q == LOCKED);

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: default 4-entry instance plus a DEPTH=5 / ADDR_W=3 instance.
module tb_prog_mem;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default instance
    logic       a_fetch_req, a_wr_en, a_lock_set;
    logic [1:0] a_fetch_addr, a_wr_addr, a_wr_data;
    logic       a_fetch_valid, a_fetch_err, a_wr_err, a_locked;
    logic [1:0] a_fetch_data;

    // DEPTH=5, ADDR_W=3 instance
    logic       b_fetch_req, b_wr_en, b_lock_set;
    logic [2:0] b_fetch_addr, b_wr_addr;
    logic [1:0] b_wr_data;
    logic       b_fetch_valid, b_fetch_err, b_wr_err, b_locked;
    logic [1:0] b_fetch_data;

    int errors = 0;
    int checks = 0;

    prog_mem dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr),
        .fetch_valid(a_fetch_valid), .fetch_data(a_fetch_data), .fetch_err(a_fetch_err),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_err(a_wr_err),
        .lock_set(a_lock_set), .locked(a_locked)
    );

    prog_mem #(.DEPTH(5), .ADDR_W(3), .OP_W(2), .HLT_OP(2'b10)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr),
        .fetch_valid(b_fetch_valid), .fetch_data(b_fetch_data), .fetch_err(b_fetch_err),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_err(b_wr_err),
        .lock_set(b_lock_set), .locked(b_locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_fetch_req = 0; a_fetch_addr = 0; a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_lock_set = 0;
        b_fetch_req = 0; b_fetch_addr = 0; b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_lock_set = 0;
        #2;
        chk("rst_valid", 32'(a_fetch_valid), 0);
        chk("rst_data",  32'(a_fetch_data),  0);
        chk("rst_err",   32'(a_fetch_err),   0);
        chk("rst_wr_err", 32'(a_wr_err),     0);
        chk("rst_locked", 32'(a_locked),     0);
        tick();
        tick();
        rst_n = 1'b1;

        // Default program fetch 0..3
        a_fetch_req = 1; a_fetch_addr = 0;
        tick();
        chk("f0_valid", 32'(a_fetch_valid), 1);
        chk("f0_data",  32'(a_fetch_data),  0);
        chk("f0_err",   32'(a_fetch_err),   0);
        a_fetch_addr = 1;
        tick();
        chk("f1_valid", 32'(a_fetch_valid), 1);
        chk("f1_data",  32'(a_fetch_data),  1);
        a_fetch_addr = 2;
        tick();
        chk("f2_data",  32'(a_fetch_data),  0);
        chk("f2_err",   32'(a_fetch_err),   0);
        a_fetch_addr = 3;
        tick();
        chk("f3_valid", 32'(a_fetch_valid), 1);
        chk("f3_data",  32'(a_fetch_data),  2);
        a_fetch_req = 0;
        tick();
        chk("idle_valid", 32'(a_fetch_valid), 0);
        chk("idle_hold",  32'(a_fetch_data),  2);
        chk("idle_err",   32'(a_fetch_err),   0);

        // Write then fetch
        a_wr_en = 1; a_wr_addr = 2; a_wr_data = 2'b01;
        tick();
        chk("wr2_no_err", 32'(a_wr_err), 0);
        a_wr_en = 0; a_fetch_req = 1; a_fetch_addr = 2;
        tick();
        chk("wr2_fetch", 32'(a_fetch_data), 1);
        // Bypass: write and fetch address 3 together
        a_wr_en = 1; a_wr_addr = 3; a_wr_data = 2'b11; a_fetch_addr = 3;
        tick();
        chk("bypass_valid", 32'(a_fetch_valid), 1);
        chk("bypass_data",  32'(a_fetch_data),  3);
        a_wr_en = 0; a_fetch_req = 0;

        // Lock with simultaneous write
        a_lock_set = 1; a_wr_en = 1; a_wr_addr = 0; a_wr_data = 2'b01;
        tick();
        chk("lock_locked", 32'(a_locked), 1);
        chk("lock_wr_ok",  32'(a_wr_err), 0);
        a_lock_set = 0; a_wr_data = 2'b10;
        tick();
        chk("locked_wr_err", 32'(a_wr_err), 1);
        a_wr_en = 0;
        tick();
        chk("wr_err_pulse", 32'(a_wr_err), 0);
        chk("still_locked", 32'(a_locked), 1);
        a_fetch_req = 1; a_fetch_addr = 0;
        tick();
        chk("lock_fetch0", 32'(a_fetch_data), 1);
        // Rejected write must not bypass into a same-address fetch
        a_wr_en = 1; a_wr_addr = 1; a_wr_data = 2'b11; a_fetch_addr = 1;
        tick();
        chk("rej_no_bypass", 32'(a_fetch_data), 1);
        chk("rej_wr_err",    32'(a_wr_err),     1);
        a_wr_en = 0;

        // fetch_req toggle 1,0,1
        a_fetch_addr = 3;
        tick();
        chk("tog1_valid", 32'(a_fetch_valid), 1);
        chk("tog1_data",  32'(a_fetch_data),  3);
        a_fetch_req = 0; a_fetch_addr = 0;
        tick();
        chk("tog0_valid", 32'(a_fetch_valid), 0);
        chk("tog0_hold",  32'(a_fetch_data),  3);
        a_fetch_req = 1; a_fetch_addr = 1;
        tick();
        chk("tog2_valid", 32'(a_fetch_valid), 1);
        chk("tog2_data",  32'(a_fetch_data),  1);
        a_fetch_req = 0;

        // DEPTH=5 instance: out-of-range fetch/write and boundary entry
        b_fetch_req = 1; b_fetch_addr = 6;
        tick();
        chk("b_oor_data",  32'(b_fetch_data), 2);
        chk("b_oor_err",   32'(b_fetch_err),  1);
        chk("b_oor_valid", 32'(b_fetch_valid), 1);
        b_fetch_req = 0; b_wr_en = 1; b_wr_addr = 7; b_wr_data = 2'b01;
        tick();
        chk("b_oor_wr_err", 32'(b_wr_err), 1);
        chk("b_idle_err",   32'(b_fetch_err), 0);
        b_wr_en = 0; b_fetch_req = 1;
        for (int i = 0; i < 5; i++) begin
            b_fetch_addr = 3'(i);
            tick();
            chk($sformatf("b_entry%0d", i), 32'(b_fetch_data), (i == 0 || i == 2) ? 0 : ((i == 1) ? 1 : 2));
            chk($sformatf("b_entry%0d_err", i), 32'(b_fetch_err), 0);
        end
        b_fetch_addr = 5;
        tick();
        chk("b_addr5_err", 32'(b_fetch_err), 1);
        b_fetch_req = 0; b_wr_en = 1; b_wr_addr = 4; b_wr_data = 2'b01;
        tick();
        chk("b_wr4_ok", 32'(b_wr_err), 0);
        b_wr_en = 0; b_fetch_req = 1; b_fetch_addr = 4;
        tick();
        chk("b_wr4_fetch", 32'(b_fetch_data), 1);
        b_fetch_req = 0;

        // Load new program into default instance is blocked (locked); outputs nonzero, then async reset
        a_fetch_req = 1; a_fetch_addr = 3;
        tick();
        chk("pre_rst_data", 32'(a_fetch_data), 3);
        a_fetch_req = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  32'(a_fetch_valid), 0);
        chk("arst_data",   32'(a_fetch_data),  0);
        chk("arst_locked", 32'(a_locked),      0);
        chk("arst_b_data", 32'(b_fetch_data),  0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        a_fetch_req = 1;
        for (int i = 0; i < 4; i++) begin
            a_fetch_addr = 2'(i);
            tick();
            chk($sformatf("post_rst_f%0d", i), 32'(a_fetch_data), (i == 1) ? 1 : ((i == 3) ? 2 : 0));
        end
        a_fetch_req = 0;
        b_fetch_req = 1; b_fetch_addr = 4;
        tick();
        chk("post_rst_b4", 32'(b_fetch_data), 2);
        b_fetch_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised, writable instruction memory for the toy CPU, replacing the fixed 4-entry combinational instruction decode table. It holds `DEPTH` opcodes of `OP_W` bits and returns one opcode per fetch with one cycle of registered latency. On reset it comes up holding the default program (INC, JNO, INC, HLT). A program-load write port and a sticky write-lock allow software-style reprogramming before execution starts. The block sits between the program counter and the instruction decoder.

## Interface
- `DEPTH`, default 4: number of opcode entries; must be ≥4 and ≤ 2^`ADDR_W`.
- `ADDR_W`, default 2: address width.
- `OP_W`, default 2: opcode width; must be ≥2.
- `HLT_OP`, default 2'b10: opcode returned for out-of-range fetches and used to fill unused entries at reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  fetch request, sampled each cycle.
- `fetch_addr`  in  `ADDR_W`  fetch address.
- `fetch_valid`  out  1  `fetch_data` is valid this cycle.
- `fetch_data`  out  `OP_W`  fetched opcode.
- `fetch_err`  out  1  the fetch returned by this response was out of range.
- `wr_en`  in  1  program-load write strobe.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `OP_W`  write opcode.
- `wr_err`  out  1  one-cycle pulse when a write is rejected.
- `lock_set`  in  1  sets the sticky write lock.
- `locked`  out  1  lock state.

## Operation
- Reset (`rst_n`=0, asynchronous): entry0=INC (0), entry1=JNO (1), entry2=0, entry3=HLT (2), entries 4..DEPTH-1=`HLT_OP`. All opcodes are zero-extended to `OP_W`.
- Reset values of outputs: `fetch_valid`=0, `fetch_data`=0, `fetch_err`=0, `wr_err`=0, `locked`=0.
- Reset asserted mid-operation overrides everything. Any program loaded after the previous reset is lost, and the memory reverts to the default program.
- Fetch: when `fetch_req`=1 at edge N:
  - At N+1, `fetch_valid`=1 and `fetch_data`=mem[`fetch_addr`].
  - If `fetch_addr` ≥ `DEPTH`, `fetch_data`=`HLT_OP` and `fetch_err`=1.
  - When `fetch_req`=0, the next cycle has `fetch_valid`=0 and `fetch_err`=0, and `fetch_data` holds its last value.
- Write: at the edge where `wr_en`=1, the write is accepted only if `locked`=0 and `wr_addr` < `DEPTH`; accepted writes update mem[`wr_addr`]=`wr_data`.
- A rejected write (locked or out of range) leaves memory unchanged and drives `wr_err`=1 for exactly the following cycle.
- Lock: two states, UNLOCKED → LOCKED on `lock_set`=1. There is no transition back except reset.
- Simultaneous `lock_set` and `wr_en` in the same cycle: the write is evaluated against the pre-edge lock state. The write succeeds if the block was unlocked, and the lock applies from the next cycle.
- Simultaneous fetch and accepted write to the same address: the fetch returns the newly written data (write-through bypass).
- A fetch and a write to different addresses in the same cycle are independent.

## Timing
- Fetch latency is 1 cycle. Back-to-back fetches are fully pipelined: one response per cycle, in request order.
- Write takes effect at the edge where it is sampled, so a fetch of that address at the next edge sees the new data.
- `wr_err` and `locked` are registered; `locked` rises one cycle after `lock_set` is sampled.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then fetch addresses 0,1,2,3 on consecutive cycles → `fetch_valid`=1 for 4 cycles starting 1 cycle after the first request; `fetch_data`=0,1,0,2; `fetch_err`=0 throughout.
- Write 2'b01 to address 2, then fetch address 2 → `fetch_data`=1. Write 2'b11 to address 3 while fetching address 3 in the same cycle → response is 3 (bypass).
- Assert `lock_set` and write 2'b01 to address 0 in the same cycle → write succeeds and `locked`=1 next cycle. A later write of 2'b10 to address 0 → `wr_err` pulses once, and a fetch of address 0 still returns 1.
- With `DEPTH`=5, `ADDR_W`=3: fetch address 6 → `fetch_data`=2 (`HLT_OP`), `fetch_err`=1. A write to address 7 → `wr_err`=1 and no entry changes. Fetch address 4 → 2 with `fetch_err`=0.
- Load a new program, lock, then assert `rst_n`=0 asynchronously between clock edges → outputs go to 0 immediately and `locked`=0. After release, fetching 0..3 returns 0,1,0,2.
- Toggle `fetch_req` 1,0,1 → `fetch_valid` follows 1,0,1 delayed by one cycle, and `fetch_data` holds its value during the idle cycle.
